// File: rtl/mem_access.sv
// Load/store unit between EX and WB: passes non-memory results through, runs
// one big-endian bus transfer per aligned load/store, and flags faults.
module mem_access #(
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [31:0]           store_data_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic                  whilo_i,
  input  logic [31:0]           hi_i,
  input  logic [31:0]           lo_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  whilo_o,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  valid_o,
  output logic                  misalign_o,
  output logic                  bus_err_o,
  output logic                  stall_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [3:0]            bus_sel_o,
  output logic [31:0]           bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [31:0]           bus_rdata_i
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic        is_mem, is_store, misal, timeout_hit, bus_exit;

  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LB, OP_LBU, OP_SB: lane_sel = 4'b1000 >> off;
      OP_LH, OP_LHU, OP_SH: lane_sel = off[1] ? 4'b0011 : 4'b1100;
      default:              lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [3:0] op, input logic [31:0] sd);
    case (op)
      OP_SB:   lane_wdata = {4{sd[7:0]}};
      OP_SH:   lane_wdata = {2{sd[15:0]}};
      default: lane_wdata = sd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = off[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'b0, b};
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'b0, h};
      default: load_ext = rd;
    endcase
  endfunction

  always_comb begin
    is_mem   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_SW);
    is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    case (mem_op_i)
      OP_LH, OP_LHU, OP_SH: misal = addr_i[0];
      OP_LW, OP_SW:         misal = |addr_i[1:0];
      default:              misal = 1'b0;
    endcase
    timeout_hit = (wait_cnt == TO_LAST);
    bus_exit    = bus_ack_i || timeout_hit;
  end

  // Upstream keeps inputs frozen while stalled, so the exit cycle still sees them.
  always_comb begin
    stall_o = 1'b0;
    if (!rst) begin
      if (state == IDLE) stall_o = valid_i && is_mem && !misal;
      else               stall_o = !bus_exit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      op_q        <= '0;
      off_q       <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      wdata_o     <= '0;
      whilo_o     <= 1'b0;
      hi_o        <= '0;
      lo_o        <= '0;
      valid_o     <= 1'b0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i && is_mem && !misal) begin
            state       <= BUS;
            wait_cnt    <= '0;
            op_q        <= mem_op_i;
            off_q       <= addr_i[1:0];
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store;
            bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
            bus_sel_o   <= lane_sel(mem_op_i, addr_i[1:0]);
            bus_wdata_o <= lane_wdata(mem_op_i, store_data_i);
          end else if (valid_i) begin
            wd_o       <= wd_i;
            wreg_o     <= wreg_i && !misal;
            wdata_o    <= wdata_i;
            whilo_o    <= whilo_i && !misal;
            hi_o       <= hi_i;
            lo_o       <= lo_i;
            valid_o    <= 1'b1;
            misalign_o <= misal;
          end
        end
        BUS: begin
          if (bus_exit) begin
            state     <= IDLE;
            bus_req_o <= 1'b0;
            wd_o      <= wd_i;
            hi_o      <= hi_i;
            lo_o      <= lo_i;
            valid_o   <= 1'b1;
            // A late ack in the final wait cycle still counts as success.
            wreg_o    <= wreg_i && bus_ack_i;
            whilo_o   <= whilo_i && bus_ack_i;
            bus_err_o <= !bus_ack_i;
            wdata_o   <= (op_q >= OP_SB || !bus_ack_i) ? wdata_i
                                                       : load_ext(op_q, off_q, bus_rdata_i);
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, bus address width; REG_ADDR_W, default 5, register-index width; TIMEOUT, default 255, maximum bus wait cycles (1..65535).
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  instruction present
- mem_op_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
- addr_i  in  ADDR_W  effective address
- store_data_i  in  32  store source
- wd_i / wreg_i / wdata_i  in  REG_ADDR_W / 1 / 32  GPR writeback index / enable / data
- whilo_i / hi_i / lo_i  in  1 / 32 / 32  HI/LO write enable / values
- wd_o / wreg_o / wdata_o / whilo_o / hi_o / lo_o  out  same widths  registered writeback to WB
- valid_o  out  1  registered result valid
- misalign_o / bus_err_o  out  1  one-cycle fault flags, aligned with valid_o
- stall_o  out  1  combinational, upstream holds all inputs stable while 1
- bus_req_o / bus_we_o  out  1  request / write
- bus_addr_o  out  ADDR_W  word address, low 2 bits zero
- bus_sel_o  out  4  byte enables, bit3 = bits 31:24
- bus_wdata_o  out  32  write data
- bus_ack_i  in  1  transfer complete
- bus_rdata_i  in  32  read data, valid with bus_ack_i

Function
REQ-003 SHALL be big-endian: addr[1:0]=0 selects bits 31:24, 3 selects bits 7:0; halfword at addr[1]=0 selects bits 31:16.
REQ-004 SHALL implement FSM states IDLE and BUS; only IDLE accepts new input.
REQ-005 Non-memory op with valid_i in IDLE: all *_i values SHALL appear on outputs, valid_o=1, one cycle after; stall_o=0.
REQ-006 Misalignment: LH/LHU/SH with addr_i[0]=1, LW/SW with addr_i[1:0]!=0; SHALL issue no bus access, output next cycle with wreg_o=0, whilo_o=0, misalign_o=1.
REQ-007 Aligned memory op in IDLE: stall_o=1 that cycle; next edge SHALL enter BUS with bus_req_o=1 and bus_addr_o, bus_we_o, bus_sel_o, bus_wdata_o registered and held constant until exit.
REQ-008 bus_sel_o: byte ops one-hot per REQ-003, half ops 4'b1100 or 4'b0011, word ops 4'b1111; bus_wdata_o replicates store byte x4 / half x2 / word.
REQ-009 In BUS, stall_o SHALL equal NOT exit-condition; exit on bus_ack_i or timeout; next edge: bus_req_o=0, state IDLE, result registered with valid_o=1.
REQ-010 Loads: wdata_o = selected lane, LB/LH sign-extended, LBU/LHU zero-extended, LW raw; wreg_o/wd_o from inputs. Stores: wdata_o=wdata_i.
REQ-011 16-bit wait counter SHALL clear on BUS entry, increment each BUS cycle without ack; counter = TIMEOUT-1 without ack is timeout: wreg_o=0, whilo_o=0, bus_err_o=1.
REQ-012 bus_ack_i in the timeout cycle SHALL win (normal completion, no bus_err_o).
REQ-013 bus_ack_i while in IDLE SHALL be ignored.
REQ-014 valid_o, misalign_o, bus_err_o SHALL be 0 on every cycle without a completing result; other outputs hold last value.
REQ-015 valid_i=0 in IDLE: valid_o=0, no bus activity, stall_o=0.

Reset
REQ-016 rst=1 at an edge SHALL force: state IDLE, counter 0, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_sel_o=0, bus_wdata_o=0, wd_o=0, wreg_o=0, wdata_o=0, whilo_o=0, hi_o=0, lo_o=0, valid_o=0, misalign_o=0, bus_err_o=0.
REQ-017 rst during BUS SHALL abandon the transfer with no result; stall_o=0 while rst=1.

Verification
REQ-018 ALU op, wd_i=5, wreg_i=1, wdata_i=0x1234, whilo_i=1, hi_i=7, lo_i=9 -> next cycle valid_o=1, same values out, stall_o=0.
REQ-019 LB addr=0x103, rdata=0x000000F0, ack after 3 BUS cycles -> sel=0001, addr=0x100, stall_o=1 for 4 cycles, wdata_o=0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-020 SH addr=0x202, store_data_i=0xABCD -> bus_we_o=1, sel=0011, wdata=0xABCDABCD, addr=0x200.
REQ-021 LW addr=0x101 -> no bus_req_o, next cycle misalign_o=1, wreg_o=0.
REQ-022 TIMEOUT=4, never ack -> bus_req_o 4 cycles, then bus_err_o=1, wreg_o=0; repeat with ack on 4th cycle -> normal result, bus_err_o=0.
REQ-023 rst in 2nd BUS cycle, then ack -> bus_req_o=0 after edge, valid_o stays 0, ack ignored.
